// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states, defaults.
// SHIFTER_MULTISTEP_EN raises the per-cycle step from 1 bit to up to 4 bits.
package shifter_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SHAMT_W = 4;
    localparam int STEP_W      = 3;

`ifdef SHIFTER_MULTISTEP_EN
    localparam int MAX_STEP = 4;
`else
    localparam int MAX_STEP = 1;
`endif

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Any op with the top bit set is an arithmetic right shift.
    function automatic logic is_sra(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single shift step of 0..MAX_STEP bit positions; no rotation.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [1:0]        op,
    input  logic [STEP_W-1:0] amt,
    output logic [WIDTH-1:0]  result
);

    always_comb begin
        result = value << amt;
        if (is_sra(op)) begin
            result = $signed(value) >>> amt;
        end else if (op == OP_SRL) begin
            result = value >> amt;
        end
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit with start/busy/done handshake.
// Define SHIFTER_MULTISTEP_EN to shift up to 4 bits per cycle instead of 1.
//
// Handshake: start is sampled only in IDLE or DONE; busy is high exactly while
// in SHIFT; done is a one-cycle pulse during which dalja holds the new result.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   hyrja,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dalja,
    output logic [1:0]         dbg_state
);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         op_q;

    logic               accept;
    logic [WIDTH-1:0]   src_val;
    logic [1:0]         src_op;
    logic [SHAMT_W-1:0] src_cnt;
    logic [STEP_W-1:0]  amt;
    logic [SHAMT_W-1:0] rem;
    logic [WIDTH-1:0]   shifted;

    // The accepting edge already performs the first step, so count holds the
    // bits still outstanding after each edge and DONE follows when it hits 0.
    always_comb begin
        accept  = start && (state == ST_IDLE || state == ST_DONE);
        src_val = accept ? hyrja : work;
        src_op  = accept ? op    : op_q;
        src_cnt = accept ? shamt : count;
        amt     = (src_cnt > SHAMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(src_cnt);
        rem     = src_cnt - SHAMT_W'(amt);
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value  (src_val),
        .op     (src_op),
        .amt    (amt),
        .result (shifted)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            work  <= '0;
            count <= '0;
            op_q  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dalja <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q  <= op;
                        work  <= shifted;
                        count <= rem;
                        if (rem == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            dalja <= shifted;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work  <= shifted;
                    count <= rem;
                    if (rem == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        dalja <= shifted;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: expected results queued at issue time,
// popped and compared by a monitor whenever done is seen.
module tb_iterative_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] SRA_ALT = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] hyrja = '0;
    logic [3:0]  shamt = '0;
    logic [1:0]  op    = '0;
    logic        busy;
    logic        done;
    logic [15:0] dalja;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    iterative_shifter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .hyrja     (hyrja),
        .shamt     (shamt),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .dalja     (dalja),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_latency(input int s);
`ifdef SHIFTER_MULTISTEP_EN
        return (s == 0) ? 1 : (s + 3) / 4;
`else
        return (s == 0) ? 1 : s;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // driver: start is raised for exactly one edge; returns 1ns after that edge
    task automatic launch(input logic [15:0] h, input logic [3:0] s, input logic [1:0] o,
                          input logic [15:0] e, input bit expect_result);
        hyrja = h;
        shamt = s;
        op    = o;
        start = 1'b1;
        if (expect_result) exp_q.push_back(e);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // counts cycles after the accepting edge until done; returns at done's negedge
    task automatic wait_done(input int s, input string name);
        int cyc;
        int bsy;
        bit seen;
        cyc = 0;
        bsy = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (done) seen = 1;
            else if (busy) bsy++;
        end
        n_checks++;
        if (!seen || cyc != exp_latency(s)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, cyc, seen, exp_latency(s));
        end
        n_checks++;
        if (bsy != exp_latency(s) - 1) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, bsy, exp_latency(s) - 1);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (busy && done) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy_done_overlap: busy=%b done=%b, expected not both", busy, done);
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: dalja=%h, expected no result", dalja);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (dalja !== e) begin
                        n_fail++;
                        $display("FAIL result: dalja=%h, expected %h", dalja, e);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        check("reset_busy",  {15'd0, busy}, 16'd0);
        check("reset_done",  {15'd0, done}, 16'd0);
        check("reset_dalja", dalja, 16'h0000);
        check("reset_state", {14'd0, dbg_state}, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        launch(16'h0001, 4'd15, SLL, 16'h8000, 1);
        wait_done(15, "sll15");

        launch(16'h8000, 4'd4, SRA, 16'hF800, 1);
        wait_done(4, "sra4");
        launch(16'h8000, 4'd4, SRL, 16'h0800, 1);
        wait_done(4, "srl4");
        @(negedge clock);
        check("done_pulse_width", {15'd0, done}, 16'd0);
        check("dalja_hold", dalja, 16'h0800);

        launch(16'h1234, 4'd0, SRA, 16'h1234, 1);
        wait_done(0, "shamt0");

        launch(16'h00FF, 4'd8, SLL, 16'hFF00, 1);
        fork
            wait_done(8, "ignore_start");
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clock);
                    #1;
                    hyrja = 16'hFFFF;
                    shamt = 4'd1;
                    op    = SRL;
                    start = 1'b1;
                    @(posedge clock);
                    #1 start = 1'b0;
                end
            end
        join

        // second start raised during the done cycle of the first
        launch(16'hF0F0, 4'd4, SRL, 16'h0F0F, 1);
        wait_done(4, "b2b_first");
        launch(16'hF000, 4'd12, SRA, 16'hFFFF, 1);
        wait_done(12, "b2b_second");

        launch(16'h7FFF, 4'd15, SRA, 16'h0000, 1);
        wait_done(15, "sra_pos15");
        launch(16'hFFFF, 4'd15, SRL, 16'h0001, 1);
        wait_done(15, "srl15");
        launch(16'h1234, 4'd1, SLL, 16'h2468, 1);
        wait_done(1, "sll1");
        launch(16'h8001, 4'd1, SRA_ALT, 16'hC000, 1);
        wait_done(1, "sra_op11");
        launch(16'hC3A5, 4'd6, SRA, 16'hFF0E, 1);
        wait_done(6, "sra6");

        // asynchronous reset in the middle of a shift
        launch(16'hAAAA, 4'd10, SRL, 16'h0000, 0);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("abort_busy",  {15'd0, busy}, 16'd0);
        check("abort_done",  {15'd0, done}, 16'd0);
        check("abort_dalja", dalja, 16'h0000);
        check("abort_state", {14'd0, dbg_state}, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) check("abort_no_done", {15'd0, done}, 16'd0);
        end
        check("abort_idle", {14'd0, dbg_state}, 16'd0);
        @(posedge clock);
        #1;
        launch(16'h0003, 4'd2, SLL, 16'h000C, 1);
        wait_done(2, "after_reset");

        repeat (3) @(negedge clock);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
